// File: rtl/nios_e_system_irq_ctrl.sv
// Interrupt aggregator: syncs, latches and masks up to 16 sources into one CPU irq, with an Avalon-MM register file.
// Latency: irq_in edge to irq is SYNC_STAGES+2 cycles; readdata is registered one cycle after address.
// Backpressure: none; the slave accepts every access with fixed timing and never stalls.
module nios_e_system_irq_ctrl #(
    parameter int          NUM_IRQ     = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] EDGE_RESET  = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    input  logic [15:0] irq_in,
    output logic        irq
);

    localparam logic [15:0] VALID_MASK = 16'hFFFF >> (16 - NUM_IRQ);

    logic [15:0] irq_src;
    logic [15:0] s;
    logic [15:0] prev;
    logic [15:0] pending;
    logic [15:0] mask;
    logic [15:0] edge_cfg;
    logic [15:0] forced;

    assign irq_src = irq_in & VALID_MASK;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = irq_src;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][15:0] sync_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= irq_src;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic        wr;
    logic [15:0] wdat;
    logic [15:0] clr_bits;
    logic [15:0] force_bits;
    logic [15:0] set_bits;
    logic [15:0] pend_edge;
    logic [15:0] forced_nxt;
    logic [15:0] pending_nxt;
    logic [15:0] edge_nxt;
    logic [15:0] mask_nxt;
    logic [15:0] prev_nxt;

    assign wr         = chipselect & ~write_n;
    assign wdat       = writedata & VALID_MASK;
    assign clr_bits   = (wr && address == 3'd0) ? wdat : 16'h0000;
    assign force_bits = (wr && address == 3'd5) ? wdat : 16'h0000;
    assign set_bits   = (edge_cfg & s & ~prev) | (~edge_cfg & s);

    // Level bits track s, but a forced level bit stays up until software clears it.
    assign forced_nxt  = (forced & ~clr_bits) | force_bits;
    assign pend_edge   = (pending & ~clr_bits) | set_bits | force_bits;
    assign pending_nxt = ((edge_cfg & pend_edge) | (~edge_cfg & (s | forced_nxt))) & VALID_MASK;

    assign edge_nxt = (wr && address == 3'd2) ? wdat : edge_cfg;
    assign mask_nxt = (wr && address == 3'd1) ? wdat : mask;
    assign prev_nxt = s & ~(edge_cfg ^ edge_nxt);

    logic [15:0] active;
    logic [4:0]  vec_idx;
    logic [15:0] vector;
    logic [15:0] rd_mux;

    assign active = pending & mask;

    always_comb begin
        vec_idx = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (active[i]) begin
                vec_idx = 5'(i);
            end
        end
    end

    assign vector = {|active, 10'b0, vec_idx};

    always_comb begin
        rd_mux = 16'h0000;
        case (address)
            3'd0:    rd_mux = pending;
            3'd1:    rd_mux = mask;
            3'd2:    rd_mux = edge_cfg;
            3'd3:    rd_mux = s;
            3'd4:    rd_mux = vector;
            default: rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 16'h0000;
            irq      <= 1'b0;
            pending  <= 16'h0000;
            mask     <= 16'h0000;
            edge_cfg <= EDGE_RESET & VALID_MASK;
            forced   <= 16'h0000;
            prev     <= 16'h0000;
        end else begin
            readdata <= rd_mux;
            irq      <= |active;
            pending  <= pending_nxt;
            mask     <= mask_nxt;
            edge_cfg <= edge_nxt;
            forced   <= forced_nxt;
            prev     <= prev_nxt;
        end
    end

endmodule
